spi_slave_if: RTL and testbench

- Serial front end for the single-port RAM: deserialises MOSI frames into 10-bit command/data words and hands them to the RAM on rx_data/rx_valid.
- Takes the RAM's tx_data/tx_valid read result and serialises it onto MISO.
- The SPI bit clock is the system clock clk; all SPI pins are sampled on the rising edge of clk.

---
 rtl/spi_slave_if.sv | 116 +++++++++++
 tb/tb_spi_slave_if.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: MOSI frames become 10-bit words on
// rx_data/rx_valid, and RAM read bytes are shifted back out on MISO.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  input  logic                 tx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  output logic                 MISO
);

  localparam int WORD_W = ADDR_SIZE + 2;
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int TXC_W  = $clog2(ADDR_SIZE);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WORD_W-2:0]  rx_shift;
  logic               rd_addr_flag;
  logic               arm_pend, armed, tx_busy;
  logic [ADDR_SIZE-2:0] tx_shift;
  logic [TXC_W-1:0]   tx_cnt;
  logic               in_frame, last_bit, abort;

  assign in_frame = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  // An SS_n rise wins over the final payload bit on the same edge.
  assign last_bit = in_frame && !SS_n && (bit_cnt == CNT_W'(WORD_W - 1));
  assign abort    = (state != IDLE) && SS_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (rd_addr_flag) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      default: if (SS_n) next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
    end else begin
      rx_valid <= last_bit;
      if (!in_frame || SS_n) begin
        bit_cnt <= '0;
      end else if (bit_cnt != CNT_W'(WORD_W)) begin
        rx_shift <= {rx_shift[WORD_W-3:0], MOSI};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (last_bit) begin
        rx_data <= {rx_shift, MOSI};
        if (state == READ_ADD)  rd_addr_flag <= 1'b1;
        if (state == READ_DATA) rd_addr_flag <= 1'b0;
      end
    end
  end

  // Read return: arm one edge after rx_valid so a stale tx_valid level cannot
  // load before the RAM has seen the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_pend <= 1'b0;
      armed    <= 1'b0;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      MISO     <= 1'b0;
    end else if (abort) begin
      arm_pend <= 1'b0;
      armed    <= 1'b0;
      tx_busy  <= 1'b0;
      MISO     <= 1'b0;
    end else begin
      arm_pend <= last_bit && (state == READ_DATA);
      if (arm_pend) armed <= 1'b1;
      if (armed && tx_valid) begin
        MISO     <= tx_data[ADDR_SIZE-1];
        tx_shift <= tx_data[ADDR_SIZE-2:0];
        tx_cnt   <= TXC_W'(ADDR_SIZE - 1);
        armed    <= 1'b0;
        tx_busy  <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt != '0) begin
          MISO     <= tx_shift[ADDR_SIZE-2];
          tx_shift <= tx_shift << 1;
          tx_cnt   <= tx_cnt - TXC_W'(1);
        end else begin
          MISO    <= 1'b0;
          tx_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write/read frames, read-back serialisation,
// aborts and asynchronous reset.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, tx_valid;
  logic [7:0] tx_data;
  logic [9:0] rx_data;
  logic       rx_valid, MISO;

  int nvec = 0;
  int nerr = 0;
  int pulses, pulse_at, step;
  logic [9:0] pulse_data;
  logic miso_hi;
  logic miso_log [0:15];

  always #5 clk = ~clk;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .MISO(MISO)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic ss, input logic mosi);
    SS_n = ss;
    MOSI = mosi;
    tick();
    if (rx_valid) begin
      if (pulses == 0) pulse_at = step;
      pulses++;
      pulse_data = rx_data;
    end
    if (MISO) miso_hi = 1'b1;
    step++;
  endtask

  // E0, command bit, nbits payload bits, extra MOSI=1 bits, then SS_n high
  // (the first closing edge carries MOSI=1 to probe the late-abort case).
  task automatic run_frame(input logic cmd, input logic [9:0] w, input int nbits, input int extra);
    pulses = 0; pulse_at = -1; miso_hi = 1'b0; step = -2;
    for (int k = 0; k < 16; k++) miso_log[k] = 1'b0;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, cmd);
    for (int i = 0; i < nbits; i++) drive_bit(1'b0, w[9-i]);
    for (int k = 0; k < extra; k++) begin
      drive_bit(1'b0, 1'b1);
      if (k < 16) miso_log[k] = MISO;
    end
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b1; tx_data = 8'hC3;
    tick(); tick();
    nvec++; if (rx_data !== 10'h000) begin nerr++; $display("FAIL reset_rx_data got %h want 000", rx_data); end
    nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    nvec++; if (MISO !== 1'b0) begin nerr++; $display("FAIL reset_miso got %b want 0", MISO); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_addr();
    run_frame(1'b0, 10'h03A, 10, 0);
    nvec++; if (pulses !== 1) begin nerr++; $display("FAIL wa_pulses got %0d want 1", pulses); end
    nvec++; if (pulse_at !== 9) begin nerr++; $display("FAIL wa_latency got %0d want 9", pulse_at); end
    nvec++; if (pulse_data !== 10'h03A) begin nerr++; $display("FAIL wa_data got %h want 03a", pulse_data); end
    nvec++; if (dut.rd_addr_flag !== 1'b0) begin nerr++; $display("FAIL wa_flag got %b want 0", dut.rd_addr_flag); end
    nvec++; if (miso_hi !== 1'b0) begin nerr++; $display("FAIL wa_miso got %b want 0", miso_hi); end
  endtask

  task automatic test_write_data();
    run_frame(1'b0, 10'h1A5, 10, 5);
    nvec++; if (pulses !== 1) begin nerr++; $display("FAIL wd_pulses got %0d want 1", pulses); end
    nvec++; if (pulse_data !== 10'h1A5) begin nerr++; $display("FAIL wd_data got %h want 1a5", pulse_data); end
    nvec++; if (rx_data !== 10'h1A5) begin nerr++; $display("FAIL wd_hold got %h want 1a5", rx_data); end
    nvec++; if (miso_hi !== 1'b0) begin nerr++; $display("FAIL wd_miso got %b want 0", miso_hi); end
  endtask

  task automatic test_read_addr();
    run_frame(1'b1, 10'h23A, 10, 2);
    nvec++; if (pulses !== 1) begin nerr++; $display("FAIL ra_pulses got %0d want 1", pulses); end
    nvec++; if (pulse_data !== 10'h23A) begin nerr++; $display("FAIL ra_data got %h want 23a", pulse_data); end
    nvec++; if (dut.rd_addr_flag !== 1'b1) begin nerr++; $display("FAIL ra_flag got %b want 1", dut.rd_addr_flag); end
    nvec++; if (miso_hi !== 1'b0) begin nerr++; $display("FAIL ra_miso got %b want 0", miso_hi); end
  endtask

  task automatic test_read_data();
    logic [11:0] exp_miso;
    logic [11:0] got_miso;
    exp_miso = 12'b0_1100_0011_000;
    run_frame(1'b1, 10'h300, 10, 12);
    for (int k = 0; k < 12; k++) got_miso[11-k] = miso_log[k];
    nvec++; if (pulses !== 1) begin nerr++; $display("FAIL rd_pulses got %0d want 1", pulses); end
    nvec++; if (pulse_data !== 10'h300) begin nerr++; $display("FAIL rd_data got %h want 300", pulse_data); end
    nvec++; if (got_miso !== exp_miso) begin nerr++; $display("FAIL rd_miso_serial got %b want %b", got_miso, exp_miso); end
    nvec++; if (dut.rd_addr_flag !== 1'b0) begin nerr++; $display("FAIL rd_flag got %b want 0", dut.rd_addr_flag); end
    nvec++; if (MISO !== 1'b0) begin nerr++; $display("FAIL rd_miso_idle got %b want 0", MISO); end
  endtask

  task automatic test_abort();
    run_frame(1'b0, 10'h155, 5, 0);
    nvec++; if (pulses !== 0) begin nerr++; $display("FAIL ab_pulses got %0d want 0", pulses); end
    nvec++; if (dut.state !== 3'd0) begin nerr++; $display("FAIL ab_state got %0d want 0", dut.state); end
    nvec++; if (rx_data !== 10'h300) begin nerr++; $display("FAIL ab_hold got %h want 300", rx_data); end
    run_frame(1'b0, 10'h0F0, 10, 0);
    nvec++; if (pulses !== 1 || pulse_data !== 10'h0F0) begin nerr++; $display("FAIL ab_next got %0d/%h want 1/0f0", pulses, pulse_data); end
  endtask

  task automatic test_late_abort();
    run_frame(1'b0, 10'h0FF, 9, 0);
    nvec++; if (pulses !== 0) begin nerr++; $display("FAIL la_pulses got %0d want 0", pulses); end
    nvec++; if (rx_data !== 10'h0F0) begin nerr++; $display("FAIL la_hold got %h want 0f0", rx_data); end
  endtask

  task automatic test_async_reset();
    logic [9:0] w;
    w = 10'h300;
    run_frame(1'b1, 10'h2B4, 10, 0);
    nvec++; if (dut.rd_addr_flag !== 1'b1) begin nerr++; $display("FAIL ar_flag_set got %b want 1", dut.rd_addr_flag); end
    pulses = 0; step = -2;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive_bit(1'b0, w[9-i]);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    nvec++; if (MISO !== 1'b1) begin nerr++; $display("FAIL ar_shifting got %b want 1", MISO); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (MISO !== 1'b0) begin nerr++; $display("FAIL ar_miso got %b want 0", MISO); end
    nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL ar_rx_valid got %b want 0", rx_valid); end
    nvec++; if (dut.rd_addr_flag !== 1'b0) begin nerr++; $display("FAIL ar_flag got %b want 0", dut.rd_addr_flag); end
    nvec++; if (dut.state !== 3'd0) begin nerr++; $display("FAIL ar_state got %0d want 0", dut.state); end
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(1'b1, 10'h2AA, 10, 4);
    nvec++; if (pulse_data !== 10'h2AA || miso_hi !== 1'b0) begin nerr++; $display("FAIL ar_after got %h/%b want 2aa/0", pulse_data, miso_hi); end
    nvec++; if (dut.rd_addr_flag !== 1'b1) begin nerr++; $display("FAIL ar_readd got %b want 1", dut.rd_addr_flag); end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_addr();
    test_read_data();
    test_abort();
    test_late_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
